// File: rtl/axi_b_resp_gen.sv
// axi_b_resp_gen: slave-side AXI write-response (B channel) generator.
// Accepts AW into a FIFO and counts W bursts to WLAST, folding beat errors.
// Pairs AW entries with completed bursts in order and issues one registered B each.
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   awvalid/awready        AW handshake; awid, awuser captured into the AW FIFO
//   wvalid/wready          W handshake; wready = sink_ready & burst FIFO not full
//   wlast, werr            burst end marker and per-beat sink error
//   sink_ready             downstream sink can take a W beat
//   bvalid/bready          B handshake; bid, bresp, buser registered
//   idle                   nothing queued, no error pending, no B outstanding
module axi_b_resp_gen #(
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [USER_WIDTH-1:0] awuser,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  input  logic                  werr,
  input  logic                  sink_ready,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic [USER_WIDTH-1:0] buser,
  output logic                  idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ID_WIDTH + USER_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [EW-1:0] aw_mem [DEPTH];
  ptr_t          aw_wp;
  ptr_t          aw_rp;
  cnt_t          aw_cnt;

  logic [DEPTH-1:0] dn_mem;
  ptr_t             dn_wp;
  ptr_t             dn_rp;
  cnt_t             dn_cnt;

  logic err_acc;

  logic aw_push;
  logic w_hs;
  logic dn_push;
  logic b_load;
  logic aw_ne;
  logic dn_ne;

  // Ready comes from registered counts only: a pop in the same cycle
  // does not open a slot until the following cycle.
  assign awready = (aw_cnt != FULL);
  assign wready  = sink_ready & (dn_cnt != FULL);

  assign aw_push = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign dn_push = w_hs & wlast;

  assign aw_ne  = (aw_cnt != '0);
  assign dn_ne  = (dn_cnt != '0);
  assign b_load = (~bvalid | bready) & aw_ne & dn_ne;

  assign idle = ~aw_ne & ~dn_ne & ~err_acc & ~bvalid;

  always_ff @(posedge aclk) begin
    if (aw_push) begin
      aw_mem[aw_wp] <= {awid, awuser};
    end
    if (dn_push) begin
      dn_mem[dn_wp] <= err_acc | werr;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_wp  <= '0;
      aw_rp  <= '0;
      aw_cnt <= '0;
    end else begin
      if (aw_push) begin
        aw_wp <= aw_wp + ptr_t'(1);
      end
      if (b_load) begin
        aw_rp <= aw_rp + ptr_t'(1);
      end
      unique case ({aw_push, b_load})
        2'b10:   aw_cnt <= aw_cnt + cnt_t'(1);
        2'b01:   aw_cnt <= aw_cnt - cnt_t'(1);
        default: aw_cnt <= aw_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      dn_wp   <= '0;
      dn_rp   <= '0;
      dn_cnt  <= '0;
      err_acc <= 1'b0;
    end else begin
      if (w_hs) begin
        // A burst's error state is consumed by its WLAST beat.
        err_acc <= wlast ? 1'b0 : (err_acc | werr);
      end
      if (dn_push) begin
        dn_wp <= dn_wp + ptr_t'(1);
      end
      if (b_load) begin
        dn_rp <= dn_rp + ptr_t'(1);
      end
      unique case ({dn_push, b_load})
        2'b10:   dn_cnt <= dn_cnt + cnt_t'(1);
        2'b01:   dn_cnt <= dn_cnt - cnt_t'(1);
        default: dn_cnt <= dn_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      bvalid <= 1'b0;
      bid    <= '0;
      bresp  <= 2'b00;
      buser  <= '0;
    end else if (b_load) begin
      bvalid <= 1'b1;
      {bid, buser} <= aw_mem[aw_rp];
      bresp  <= dn_mem[dn_rp] ? 2'b10 : 2'b00;
    end else if (bready) begin
      bvalid <= 1'b0;
    end
  end

endmodule
